// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: zero-stall hits, busy-wait block fill on a miss.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module instruction_cache #(
    parameter int unsigned INDEX_BITS = 3,
    parameter int unsigned TAG_BITS   = 3
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         READ,
    input  logic [31:0]                  PC,
    output logic [31:0]                  INSTRUCTION,
    output logic                         BUSYWAIT,
    output logic                         MEM_READ,
    output logic [TAG_BITS+INDEX_BITS-1:0] MEM_ADDRESS,
    input  logic [127:0]                 MEM_READDATA,
    input  logic                         MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]                  HIT_COUNT,
    output logic [15:0]                  MISS_COUNT
`endif
);

    localparam int unsigned NumBlocks = 1 << INDEX_BITS;

    typedef enum logic [1:0] {StIdle, StMemRead, StUpdate} state_e;

    state_e                state_q;
    logic [NumBlocks-1:0]  valid_q;
    logic [TAG_BITS-1:0]   tag_mem [NumBlocks];
    logic [127:0]          data_mem [NumBlocks];
    logic [127:0]          fill_q;

    logic [1:0]            offset;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic                  hit;
    logic [31:0]           word;
    logic                  unused_pc;

    assign offset    = PC[3:2];
    assign index     = PC[INDEX_BITS+3:4];
    assign tag       = PC[TAG_BITS+INDEX_BITS+3:INDEX_BITS+4];
    assign unused_pc = ^{PC[31:TAG_BITS+INDEX_BITS+4], PC[1:0]};

    assign hit = READ && valid_q[index] && (tag_mem[index] == tag);

    always_comb begin
        word = 32'h0;
        unique case (offset)
            2'd0: word = data_mem[index][31:0];
            2'd1: word = data_mem[index][63:32];
            2'd2: word = data_mem[index][95:64];
            2'd3: word = data_mem[index][127:96];
            default: word = 32'h0;
        endcase
    end

    assign INSTRUCTION = hit ? word : 32'h0;
    // Outside IDLE the CPU is always stalled; in IDLE only a missing read stalls it.
    assign BUSYWAIT    = (state_q != StIdle) || (READ && !hit);
    assign MEM_READ    = (state_q == StMemRead);
    assign MEM_ADDRESS = {tag, index};

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= StIdle;
            valid_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (READ && !hit) state_q <= StMemRead;
                end
                StMemRead: begin
                    if (!MEM_BUSYWAIT) begin
                        fill_q  <= MEM_READDATA;
                        state_q <= StUpdate;
                    end
                end
                StUpdate: begin
                    data_mem[index] <= fill_q;
                    tag_mem[index]  <= tag;
                    valid_q[index]  <= 1'b1;
                    state_q         <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            HIT_COUNT  <= 16'h0;
            MISS_COUNT <= 16'h0;
        end else if (state_q == StIdle) begin
            if (hit) HIT_COUNT <= HIT_COUNT + 16'd1;
            else if (READ) MISS_COUNT <= MISS_COUNT + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: a busy-wait memory responder plus a block-address
// reference model of the cache contents and stall timing.
module tb_instruction_cache;

    logic         clk = 1'b0;
    logic         reset;
    logic         read;
    logic [31:0]  pc;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;
`ifdef ICACHE_STATS_EN
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;
`endif

    instruction_cache dut (
        .CLK          (clk),
        .RESET        (reset),
        .READ         (read),
        .PC           (pc),
        .INSTRUCTION  (instruction),
        .BUSYWAIT     (busywait),
        .MEM_READ     (mem_read),
        .MEM_ADDRESS  (mem_address),
        .MEM_READDATA (mem_readdata),
        .MEM_BUSYWAIT (mem_busywait)
`ifdef ICACHE_STATS_EN
        ,
        .HIT_COUNT    (hit_count),
        .MISS_COUNT   (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int lat = 1;
    int rd_cnt = 0;
    logic [127:0] mem_data [64];

    // Reference model: each line remembers which 6-bit block address it holds.
    logic model_valid [8];
    int   model_blk [8];
    int   exp_hits = 0;
    int   exp_misses = 0;

    // Memory: a read lasts lat cycles; data is only correct in the cycle busy falls.
    initial begin
        mem_busywait = 1'b0;
        mem_readdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_read === 1'b1) begin
                mem_busywait = (rd_cnt < lat - 1);
                mem_readdata = mem_busywait ? {$urandom, $urandom, $urandom, $urandom}
                                            : mem_data[mem_address];
                rd_cnt++;
            end else begin
                rd_cnt = 0;
                mem_busywait = 1'b0;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) model_valid[i] = 1'b0;
        exp_hits = 0;
        exp_misses = 0;
    endtask

    task automatic fetch(input logic [31:0] addr);
        int blk, idx, off, n;
        logic exp_hit;
        logic [31:0] exp_word;
        blk = int'((addr >> 4) & 32'd63);
        idx = blk % 8;
        off = int'((addr >> 2) & 32'd3);
        exp_word = mem_data[blk][off*32 +: 32];
        exp_hit = model_valid[idx] && (model_blk[idx] == blk);
        pc = addr;
        read = 1'b1;
        #5;
        if (exp_hit) begin
            total++;
            if (busywait !== 1'b0 || mem_read !== 1'b0 || instruction !== exp_word) begin
                bad++;
                $display("FAIL hit pc=%h: busy=%b mem_read=%b instr=%h, required busy=0 mem_read=0 instr=%h",
                         addr, busywait, mem_read, instruction, exp_word);
            end
            exp_hits++;
        end else begin
            total++;
            if (busywait !== 1'b1 || mem_read !== 1'b0) begin
                bad++;
                $display("FAIL miss_detect pc=%h: busy=%b mem_read=%b, required busy=1 mem_read=0",
                         addr, busywait, mem_read);
            end
            n = 1;
            next_cycle();
            #5;
            total++;
            if (mem_read !== 1'b1 || mem_address !== 6'(blk)) begin
                bad++;
                $display("FAIL mem_request pc=%h: mem_read=%b addr=%h, required mem_read=1 addr=%h",
                         addr, mem_read, mem_address, 6'(blk));
            end
            while (busywait === 1'b1 && n < 200) begin
                n++;
                next_cycle();
                #5;
            end
            total++;
            if (n != lat + 2) begin
                bad++;
                $display("FAIL stall_length pc=%h: busy cycles=%0d, required %0d", addr, n, lat + 2);
            end
            total++;
            if (busywait !== 1'b0 || instruction !== exp_word) begin
                bad++;
                $display("FAIL fill_word pc=%h: busy=%b instr=%h, required busy=0 instr=%h",
                         addr, busywait, instruction, exp_word);
            end
            model_valid[idx] = 1'b1;
            model_blk[idx] = blk;
            exp_misses++;
            exp_hits++;
        end
        next_cycle();
        read = 1'b0;
    endtask

    task automatic idle_check(input logic [31:0] addr);
        pc = addr;
        read = 1'b0;
        #5;
        total++;
        if (busywait !== 1'b0 || mem_read !== 1'b0 || instruction !== 32'h0) begin
            bad++;
            $display("FAIL read_low pc=%h: busy=%b mem_read=%b instr=%h, required 0 0 00000000",
                     addr, busywait, mem_read, instruction);
        end
        next_cycle();
    endtask

    task automatic check_stats(input string name);
`ifdef ICACHE_STATS_EN
        total++;
        if (hit_count !== 16'(exp_hits) || miss_count !== 16'(exp_misses)) begin
            bad++;
            $display("FAIL %s: hits=%0d misses=%0d, required hits=%0d misses=%0d",
                     name, hit_count, miss_count, exp_hits, exp_misses);
        end
`else
        if (name.len() == 0) $display("unnamed stats point");
`endif
    endtask

    task automatic test_reset();
        reset = 1'b0;
        read = 1'b0;
        pc = 32'h0;
        next_cycle();
        next_cycle();
        reset = 1'b1;
        model_clear();
        #5;
        total++;
        if (busywait !== 1'b0 || mem_read !== 1'b0 || instruction !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: busy=%b mem_read=%b instr=%h, required 0 0 00000000",
                     busywait, mem_read, instruction);
        end
        check_stats("reset_stats");
        next_cycle();
    endtask

    task automatic test_cold_miss_and_hits();
        lat = 5;
        fetch(32'h000);
        fetch(32'h004);
        fetch(32'h008);
        fetch(32'h00C);
        check_stats("stats_after_hits");
    endtask

    task automatic test_conflict();
        lat = 3;
        fetch(32'h080);
        fetch(32'h084);
        fetch(32'h000);
    endtask

    task automatic test_read_low();
        for (int i = 0; i < 3; i++) idle_check(32'h3F0 + 32'(i * 4));
    endtask

    task automatic test_reset_mid_fill();
        lat = 6;
        pc = 32'h050;
        read = 1'b1;
        next_cycle();
        next_cycle();
        #5;
        total++;
        if (mem_read !== 1'b1) begin
            bad++;
            $display("FAIL mid_fill_request: mem_read=%b, required 1", mem_read);
        end
        next_cycle();
        reset = 1'b0;
        read = 1'b0;
        next_cycle();
        reset = 1'b1;
        model_clear();
        #5;
        total++;
        if (mem_read !== 1'b0 || busywait !== 1'b0) begin
            bad++;
            $display("FAIL mid_fill_reset: mem_read=%b busy=%b, required 0 0", mem_read, busywait);
        end
        check_stats("mid_fill_stats");
        for (int i = 0; i < 8; i++) next_cycle();
        lat = 2;
        fetch(32'h000);
        fetch(32'h050);
    endtask

    task automatic test_read_drop();
        lat = 4;
        pc = 32'h140;
        read = 1'b1;
        next_cycle();
        read = 1'b0;
        for (int i = 0; i < lat + 3; i++) next_cycle();
        #5;
        total++;
        if (busywait !== 1'b0 || mem_read !== 1'b0) begin
            bad++;
            $display("FAIL read_drop_idle: busy=%b mem_read=%b, required 0 0", busywait, mem_read);
        end
        model_valid[4] = 1'b1;
        model_blk[4] = 20;
        exp_misses++;
        next_cycle();
        fetch(32'h148);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        for (int i = 0; i < 80; i++) begin
            addr = ($urandom << 10) | (32'($urandom_range(0, 15)) << 4) | 32'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                idle_check(addr);
            end else begin
                lat = $urandom_range(1, 4);
                fetch(addr);
            end
        end
        check_stats("random_stats");
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem_data[i] = {$urandom, $urandom, $urandom, $urandom};
        mem_data[0][31:0] = 32'h01020304;
        model_clear();
        test_reset();
        test_cold_miss_and_hits();
        test_conflict();
        test_read_low();
        test_reset_mid_fill();
        test_read_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
